half_adder_checker: RTL and testbench

//  Synthesizable self-checking harness for the half_adder block: generates the exhaustive
//  A/B stimulus sweep and checks the returned suma/acarreo against a golden model.

---
 rtl/half_adder_pkg.sv | 19 +
 rtl/half_adder_checker_if.sv | 28 ++
 rtl/sat_counter.sv | 24 ++
 rtl/half_adder_checker.sv | 150 +++++++++++++++
 tb/tb_half_adder_checker.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/half_adder_pkg.sv
// Shared types and golden model for the half-adder self-check harness.
package half_adder_pkg;

  localparam int unsigned VEC_W = 2;

  typedef enum logic [2:0] {
    IDLE,
    DRIVE,
    WAIT,
    CHECK,
    DONE
  } state_t;

  // Golden half-adder response packed as {acarreo, suma}.
  function automatic logic [1:0] ha_model(input logic a, input logic b);
    return {a & b, a ^ b};
  endfunction

endpackage

// File: rtl/half_adder_checker_if.sv
// Stimulus/response and run-status bundle between the checker and its host.
interface half_adder_checker_if #(
  parameter int unsigned ERR_W = 3
);

  logic                                start;
  logic                                a;
  logic                                b;
  logic                                suma;
  logic                                acarreo;
  logic                                busy;
  logic                                done;
  logic                                pass;
  logic [ERR_W-1:0]                    err_count;
  logic                                first_err_valid;
  logic [half_adder_pkg::VEC_W-1:0]    first_err_vec;

  modport master (
    input  start, suma, acarreo,
    output a, b, busy, done, pass, err_count, first_err_valid, first_err_vec
  );

  modport slave (
    output start, suma, acarreo,
    input  a, b, busy, done, pass, err_count, first_err_valid, first_err_vec
  );

endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
  parameter int unsigned W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  localparam logic [W-1:0] MAX = '1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != MAX)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/half_adder_checker.sv
// Sweeps {a,b} through 00..11 PASSES times, compares the adder response
// against the golden model and reports error count and first failing vector.
module half_adder_checker
  import half_adder_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned PASSES        = 1,
  parameter int unsigned ERR_W         = 3
) (
  input logic                  clk,
  input logic                  rst,
  half_adder_checker_if.master bus
);

  localparam int unsigned SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int unsigned SWP_W = (PASSES > 1) ? $clog2(PASSES) : 1;
  localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE_CYCLES - 1);
  localparam logic [SWP_W-1:0] SWP_LAST = SWP_W'(PASSES - 1);
  localparam logic [VEC_W-1:0] VEC_LAST = '1;

  state_t            state_q, state_d;
  logic [VEC_W-1:0]  vec_q, vec_d;
  logic [VEC_W-1:0]  ab_q, ab_d;
  logic [VEC_W-1:0]  fvec_q, fvec_d;
  logic [SWP_W-1:0]  sweep_q, sweep_d;
  logic [SET_W-1:0]  settle_q, settle_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  logic              fev_q, fev_d;
  logic              err_inc_c;
  logic              err_clr_c;
  logic              mismatch_c;
  logic [ERR_W-1:0]  err_count;

  // Response is only meaningful while in CHECK; elsewhere it is ignored.
  assign mismatch_c = ({bus.acarreo, bus.suma} != ha_model(ab_q[1], ab_q[0]));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      vec_q    <= '0;
      ab_q     <= '0;
      fvec_q   <= '0;
      sweep_q  <= '0;
      settle_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
      fev_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      vec_q    <= vec_d;
      ab_q     <= ab_d;
      fvec_q   <= fvec_d;
      sweep_q  <= sweep_d;
      settle_q <= settle_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      pass_q   <= pass_d;
      fev_q    <= fev_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    vec_d     = vec_q;
    ab_d      = ab_q;
    fvec_d    = fvec_q;
    sweep_d   = sweep_q;
    settle_d  = settle_q;
    busy_d    = busy_q;
    done_d    = done_q;
    pass_d    = pass_q;
    fev_d     = fev_q;
    err_inc_c = 1'b0;
    err_clr_c = 1'b0;

    unique case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          state_d   = DRIVE;
          busy_d    = 1'b1;
          done_d    = 1'b0;
          pass_d    = 1'b0;
          fev_d     = 1'b0;
          fvec_d    = '0;
          vec_d     = '0;
          sweep_d   = '0;
          err_clr_c = 1'b1;
        end
      end
      DRIVE: begin
        ab_d     = vec_q;
        settle_d = '0;
        state_d  = WAIT;
      end
      WAIT: begin
        if (settle_q == SET_LAST) begin
          state_d = CHECK;
        end else begin
          settle_d = settle_q + SET_W'(1);
        end
      end
      CHECK: begin
        err_inc_c = mismatch_c;
        if (mismatch_c && !fev_q) begin
          fev_d  = 1'b1;
          fvec_d = ab_q;
        end
        // Final vector folds its own mismatch into pass at the same edge.
        if ((vec_q == VEC_LAST) && (sweep_q == SWP_LAST)) begin
          state_d = DONE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          pass_d  = (err_count == '0) && !mismatch_c;
        end else begin
          state_d = DRIVE;
          vec_d   = vec_q + VEC_W'(1);
          if (vec_q == VEC_LAST) begin
            sweep_d = sweep_q + SWP_W'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  sat_counter #(
    .W(ERR_W)
  ) u_err_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (err_clr_c),
    .inc  (err_inc_c),
    .count(err_count)
  );

  assign bus.a               = ab_q[1];
  assign bus.b               = ab_q[0];
  assign bus.busy            = busy_q;
  assign bus.done            = done_q;
  assign bus.pass            = pass_q;
  assign bus.err_count       = err_count;
  assign bus.first_err_valid = fev_q;
  assign bus.first_err_vec   = fvec_q;

endmodule

// File: tb/tb_half_adder_checker.sv
// Bench for half_adder_checker: two configurations driven by a fault-injectable
// half-adder, checked every cycle against an edge-count based reference.
module tb_half_adder_checker;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Per-instance reference state: edges since accepted start (-1 = idle after reset).
  int          n_m[2]    = '{-1, -1};
  logic [1:0]  held_m[2] = '{2'b00, 2'b00};
  logic [7:0]  mm[2]     = '{8'h00, 8'h00};
  logic [7:0]  fm[2]     = '{8'h00, 8'h00};
  logic        glitch[2] = '{1'b0, 1'b0};
  logic [1:0]  noise[2]  = '{2'b00, 2'b00};

  half_adder_checker_if #(.ERR_W(3)) if0 ();
  half_adder_checker_if #(.ERR_W(2)) if1 ();

  half_adder_checker #(.SETTLE_CYCLES(2), .PASSES(1), .ERR_W(3)) u0 (
    .clk(clk), .rst(rst), .bus(if0.master));
  half_adder_checker #(.SETTLE_CYCLES(1), .PASSES(2), .ERR_W(2)) u1 (
    .clk(clk), .rst(rst), .bus(if1.master));

  // Half adder under test: golden result xor a per-vector fault mask xor glitch noise.
  assign if0.suma    = (if0.a ^ if0.b) ^ fm[0][{if0.a, if0.b, 1'b0}] ^ noise[0][0];
  assign if0.acarreo = (if0.a & if0.b) ^ fm[0][{if0.a, if0.b, 1'b1}] ^ noise[0][1];
  assign if1.suma    = (if1.a ^ if1.b) ^ fm[1][{if1.a, if1.b, 1'b0}] ^ noise[1][0];
  assign if1.acarreo = (if1.a & if1.b) ^ fm[1][{if1.a, if1.b, 1'b1}] ^ noise[1][1];

  function automatic int ss(input int i); return (i == 0) ? 2 : 1; endfunction
  function automatic int pp(input int i); return (i == 0) ? 1 : 2; endfunction
  function automatic int ww(input int i); return (i == 0) ? 3 : 2; endfunction
  function automatic int tot(input int i); return 4 * pp(i) * (ss(i) + 2); endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_assert++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Expected outputs n edges after the start-sampling edge, from the sweep rules.
  function automatic void model(input int i, input int n, input logic [1:0] held,
                                input logic [7:0] m, output logic [1:0] ab,
                                output logic bsy, output logic dn, output logic ps,
                                output logic fv, output logic [1:0] fvc, output int ec);
    int per, total, checks, cnt, sat;
    per = ss(i) + 2;
    total = tot(i);
    sat = (1 << ww(i)) - 1;
    ab = 2'b00; bsy = 1'b0; dn = 1'b0; ps = 1'b0; fv = 1'b0; fvc = 2'b00; ec = 0; cnt = 0;
    if (n >= 0) begin
      bsy = (n < total);
      dn  = (n >= total);
      if (n == 0) ab = held;
      else if ((n - 1) / per >= 4 * pp(i)) ab = 2'b11;
      else ab = 2'(((n - 1) / per) % 4);
      checks = n / per;
      if (checks > 4 * pp(i)) checks = 4 * pp(i);
      for (int c = 0; c < checks; c++) begin
        if (m[2 * (c % 4) +: 2] != 2'b00) begin
          if (cnt == 0) fvc = 2'(c % 4);
          cnt++;
        end
      end
      fv = (cnt > 0);
      ec = (cnt > sat) ? sat : cnt;
      ps = dn && (cnt == 0);
    end
  endfunction

  task automatic advance(input int i, input logic st, input logic r);
    logic [1:0] ab, fvc;
    logic bsy, dn, ps, fv;
    int ec;
    if (r) begin
      n_m[i] = -1;
      held_m[i] = 2'b00;
    end else if (st && (n_m[i] < 0 || n_m[i] >= tot(i))) begin
      model(i, n_m[i], held_m[i], mm[i], ab, bsy, dn, ps, fv, fvc, ec);
      held_m[i] = ab;
      mm[i] = fm[i];
      n_m[i] = 0;
    end else if (n_m[i] >= 0 && n_m[i] < 1000000) begin
      n_m[i]++;
    end
  endtask

  task automatic compare(input int i, input logic a, input logic b, input logic bsy,
                         input logic dn, input logic ps, input logic fv,
                         input logic [1:0] fvc, input int ec);
    logic [1:0] e_ab, e_fvc;
    logic e_bsy, e_dn, e_ps, e_fv;
    int e_ec;
    model(i, n_m[i], held_m[i], mm[i], e_ab, e_bsy, e_dn, e_ps, e_fv, e_fvc, e_ec);
    chk($sformatf("u%0d.ab", i), int'({a, b}), int'(e_ab));
    chk($sformatf("u%0d.busy", i), int'(bsy), int'(e_bsy));
    chk($sformatf("u%0d.done", i), int'(dn), int'(e_dn));
    chk($sformatf("u%0d.pass", i), int'(ps), int'(e_ps));
    chk($sformatf("u%0d.first_err_valid", i), int'(fv), int'(e_fv));
    chk($sformatf("u%0d.first_err_vec", i), int'(fvc), int'(e_fvc));
    chk($sformatf("u%0d.err_count", i), ec, e_ec);
  endtask

  // Single compare process: advance the reference on each edge, then check both instances.
  always @(posedge clk) begin
    logic st0, st1, r;
    int nx;
    st0 = if0.start;
    st1 = if1.start;
    r = rst;
    #1;
    advance(0, st0, r);
    advance(1, st1, r);
    compare(0, if0.a, if0.b, if0.busy, if0.done, if0.pass, if0.first_err_valid,
            if0.first_err_vec, int'(if0.err_count));
    compare(1, if1.a, if1.b, if1.busy, if1.done, if1.pass, if1.first_err_valid,
            if1.first_err_vec, int'(if1.err_count));
    for (int i = 0; i < 2; i++) begin
      nx = n_m[i] + 1;
      if (glitch[i] && !(n_m[i] >= 0 && nx <= tot(i) && (nx % (ss(i) + 2)) == 0))
        noise[i] = 2'($urandom);
      else
        noise[i] = 2'b00;
    end
  end

  task automatic set_start(input int i, input logic v);
    if (i == 0) if0.start = v;
    else if1.start = v;
  endtask

  function automatic logic get_done(input int i);
    return (i == 0) ? if0.done : if1.done;
  endfunction

  // Leaves the caller 2 time units after the edge that samples start.
  task automatic pulse_start(input int i);
    @(posedge clk); #2;
    set_start(i, 1'b1);
    @(posedge clk); #2;
    set_start(i, 1'b0);
  endtask

  task automatic run(input int i, input logic spam, output int edges);
    pulse_start(i);
    edges = 0;
    while (!get_done(i) && edges < 200) begin
      @(posedge clk); #2;
      edges++;
      set_start(i, spam && !get_done(i) && (edges % 5 == 2));
    end
    set_start(i, 1'b0);
    if (!get_done(i)) chk($sformatf("u%0d.done_timeout", i), 0, 1);
  endtask

  initial begin
    int e;
    int k;
    if0.start = 1'b0;
    if1.start = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    chk("reset.u0.ab", int'({if0.a, if0.b}), 0);
    chk("reset.u0.busy", int'(if0.busy), 0);
    chk("reset.u1.err_count", int'(if1.err_count), 0);
    rst = 1'b0;

    // Clean adder, default configuration
    run(0, 1'b0, e);
    chk("t1.edges", e, 16);
    chk("t1.pass", int'(if0.pass), 1);
    chk("t1.err_count", int'(if0.err_count), 0);
    chk("t1.first_err_valid", int'(if0.first_err_valid), 0);
    chk("t1.ab_held", int'({if0.a, if0.b}), 3);

    // Restart from DONE with start spammed during the run
    run(0, 1'b1, e);
    chk("t5.edges", e, 16);
    chk("t5.pass", int'(if0.pass), 1);

    // Carry stuck at zero: only vector 11 fails
    fm[0] = 8'h80;
    run(0, 1'b0, e);
    chk("t2.err_count", int'(if0.err_count), 1);
    chk("t2.first_err_vec", int'(if0.first_err_vec), 3);
    chk("t2.first_err_valid", int'(if0.first_err_valid), 1);
    chk("t2.pass", int'(if0.pass), 0);

    // Inverted sum: every vector fails, 2-bit counter saturates
    fm[1] = 8'h55;
    run(1, 1'b0, e);
    chk("t3.edges", e, 24);
    chk("t3.err_count_sat", int'(if1.err_count), 3);
    chk("t3.first_err_vec", int'(if1.first_err_vec), 0);
    chk("t3.pass", int'(if1.pass), 0);
    fm[0] = 8'h55;
    run(0, 1'b0, e);
    chk("t3.u0.err_count", int'(if0.err_count), 4);

    // Reset while waiting on vector 10
    fm[0] = 8'h01;
    pulse_start(0);
    repeat (9) @(posedge clk);
    #2;
    chk("t4.ab_before_rst", int'({if0.a, if0.b}), 2);
    chk("t4.err_before_rst", int'(if0.err_count), 1);
    rst = 1'b1;
    #1;
    chk("t4.ab_in_rst", int'({if0.a, if0.b}), 0);
    chk("t4.busy_in_rst", int'(if0.busy), 0);
    chk("t4.err_in_rst", int'(if0.err_count), 0);
    fm[0] = 8'h00;
    @(posedge clk); #2;
    rst = 1'b0;
    run(0, 1'b0, e);
    chk("t4.edges", e, 16);
    chk("t4.pass", int'(if0.pass), 1);

    // Two passes, short settle, glitching response outside CHECK
    fm[1] = 8'h00;
    glitch[1] = 1'b1;
    run(1, 1'b1, e);
    chk("t6.edges", e, 24);
    chk("t6.pass", int'(if1.pass), 1);

    // Randomized runs, masks, glitches and occasional mid-run resets
    for (int t = 0; t < 30; t++) begin
      k = $urandom_range(0, 1);
      fm[k] = 8'($urandom);
      glitch[k] = 1'($urandom);
      if ($urandom_range(0, 5) == 0) begin
        pulse_start(k);
        repeat ($urandom_range(1, 20)) @(posedge clk);
        #2;
        rst = 1'b1;
        @(posedge clk); #2;
        rst = 1'b0;
      end
      run(k, 1'($urandom), e);
      chk($sformatf("rand%0d.edges", t), e, tot(k));
    end

    repeat (3) @(posedge clk);
    #2;
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
